// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: FSM states, opcode
// classes, opcode match constants and the ALU / mux select codes.
package multicycle_controller_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_BRANCH = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILLEGAL
  } instr_cls_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ and B carry immediate bits in the low opcode field; match under mask.
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] MSK_CBZ = 11'b11111111000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] MSK_B   = 11'b11111100000;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared memory port between controller and memory: request side plus the
// ready/opcode return path from the read-data bus.
interface multicycle_controller_if;
  logic        mem_req;
  logic        mem_write;
  logic        iord;
  logic        mem_ready;
  logic [10:0] opcode;

  modport master (output mem_req, mem_write, iord, input mem_ready, opcode);
  modport slave  (input mem_req, mem_write, iord, output mem_ready, opcode);
endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational 11-bit LEGv8 opcode to instruction class decode.
module opcode_classifier
  import multicycle_controller_pkg::*;
(
  input  logic [10:0] opcode,
  output instr_cls_e  cls
);
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      cls = CLS_R;
    else if (opcode == OP_LDUR)                cls = CLS_LDUR;
    else if (opcode == OP_STUR)                cls = CLS_STUR;
    else if ((opcode & MSK_CBZ) == OP_CBZ)     cls = CLS_CBZ;
    else if ((opcode & MSK_B) == OP_B)         cls = CLS_B;
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/exec/mem/wb over one
// shared memory port and drives all datapath enables and mux selects.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  multicycle_controller_if.master       mem,
  input  logic                          alu_zero,
  output logic                          ir_write,
  output logic                          pc_write,
  output logic                          pc_src,
  output logic                          reg_write,
  output logic                          reg2loc,
  output logic                          mem_to_reg,
  output logic                          alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [1:0]                    alu_op,
  output logic                          halted,
  output logic [31:0]                   instr_count
);
  logic [2:0]  state_q, state_d;
  instr_cls_e  cls_q, cls_d, fetch_cls;
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire;
  logic        mem_req, mem_write, iord;

  opcode_classifier u_cls (.opcode(mem.opcode), .cls(fetch_cls));

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    reg2loc    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // ALU computes PC+4 while the instruction read is outstanding.
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          cls_d    = fetch_cls;
          state_d  = (fetch_cls == CLS_ILLEGAL) ? ST_HALT : ST_DECODE;
        end
      end
      ST_DECODE: begin
        reg2loc = (cls_q == CLS_STUR) || (cls_q == CLS_CBZ);
        state_d = (cls_q == CLS_CBZ || cls_q == CLS_B) ? ST_BRANCH : ST_EXEC;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        if (cls_q == CLS_R) begin
          alu_op  = ALU_FUNC;
          state_d = ST_WB;
        end else begin
          alu_src_b = SRCB_IMM;
          state_d   = ST_MEM;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = (cls_q == CLS_STUR);
        if (mem.mem_ready) begin
          retire  = (cls_q == CLS_STUR);
          state_d = (cls_q == CLS_STUR) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LDUR);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        pc_src = 1'b1;
        if (cls_q == CLS_CBZ) begin
          alu_src_a = 1'b1;
          reg2loc   = 1'b1;
          alu_op    = ALU_PASS_B;
          pc_write  = alu_zero;
        end else begin
          pc_write = 1'b1;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    instr_count_d = instr_count_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cls_q         <= CLS_NONE;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign mem.mem_req   = mem_req;
  assign mem.mem_write = mem_write;
  assign mem.iord      = iord;
  assign instr_count   = instr_count_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: one table row per clock.
module tb_multicycle_controller;
  logic        clk, reset_n, alu_zero;
  logic        ir_write, pc_write, pc_src, reg_write, reg2loc, mem_to_reg, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [31:0] instr_count;
  int checks = 0, errors = 0;

  multicycle_controller_if mif();

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .mem(mif), .alu_zero(alu_zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg2loc(reg2loc), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_write, iord, ir_write, pc_write, pc_src, reg_write, reg2loc,
  //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], halted}
  localparam logic [14:0] C_IDLE  = 15'b0_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] C_FW    = 15'b1_0_0_0_0_0_0_0_0_0_01_00_0;
  localparam logic [14:0] C_FD    = 15'b1_0_0_1_1_0_0_0_0_0_01_00_0;
  localparam logic [14:0] C_DEC0  = 15'b0_0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] C_DEC1  = 15'b0_0_0_0_0_0_0_1_0_0_00_00_0;
  localparam logic [14:0] C_EXR   = 15'b0_0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [14:0] C_EXM   = 15'b0_0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [14:0] C_MEMLD = 15'b1_0_1_0_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] C_MEMST = 15'b1_1_1_0_0_0_0_0_0_0_00_00_0;
  localparam logic [14:0] C_WBR   = 15'b0_0_0_0_0_0_1_0_0_0_00_00_0;
  localparam logic [14:0] C_WBLD  = 15'b0_0_0_0_0_0_1_0_1_0_00_00_0;
  localparam logic [14:0] C_BRZ1  = 15'b0_0_0_0_1_1_0_1_0_1_00_01_0;
  localparam logic [14:0] C_BRZ0  = 15'b0_0_0_0_0_1_0_1_0_1_00_01_0;
  localparam logic [14:0] C_BRB   = 15'b0_0_0_0_1_1_0_0_0_0_00_00_0;
  localparam logic [14:0] C_HALT  = 15'b0_0_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [10:0] J      = 11'h7FF;  // junk opcode, also illegal
  localparam logic [10:0] O_ADD  = 11'h458, O_SUB = 11'h658, O_AND = 11'h450, O_ORR = 11'h550;
  localparam logic [10:0] O_LDUR = 11'h7C2, O_STUR = 11'h7C0;
  localparam logic [10:0] O_CBZ0 = 11'h5A0, O_CBZ7 = 11'h5A7, O_B = 11'h0A3;

  typedef struct {
    logic [10:0] op;
    logic        rdy;
    logic        z;
    logic [14:0] ctrl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[$];
  int   row = 0;

  function automatic logic [14:0] act_ctrl();
    return {mif.mem_req, mif.mem_write, mif.iord, ir_write, pc_write, pc_src, reg_write,
            reg2loc, mem_to_reg, alu_src_a, alu_src_b, alu_op, halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [10:0] op, input logic rdy, input logic z,
                     input logic [14:0] ctrl, input logic [31:0] cnt);
    vt.push_back('{op, rdy, z, ctrl, cnt});
  endtask

  // Drive one cycle's inputs, compare at negedge, then step past the posedge.
  task automatic run_row(input vec_t v);
    mif.opcode = v.op; mif.mem_ready = v.rdy; alu_zero = v.z;
    @(negedge clk);
    chk($sformatf("row%0d ctrl", row), {17'd0, act_ctrl()}, {17'd0, v.ctrl});
    chk($sformatf("row%0d count", row), instr_count, v.cnt);
    row++;
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [10:0] op, input logic rdy, input logic z,
                      input logic [14:0] ctrl, input logic [31:0] cnt);
    vec_t v;
    v = '{op, rdy, z, ctrl, cnt};
    run_row(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset ctrl", {17'd0, act_ctrl()}, 32'd0);
    chk("reset count", instr_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; alu_zero = 1'b0; mif.mem_ready = 1'b0; mif.opcode = 11'd0;
    #3;
    chk("por ctrl", {17'd0, act_ctrl()}, 32'd0);
    chk("por count", instr_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    add(J, 1, 0, C_IDLE, 0);
    // ADD, ready tied high
    add(O_ADD, 1, 0, C_FD, 0); add(J, 1, 0, C_DEC0, 0); add(J, 1, 0, C_EXR, 0); add(J, 1, 0, C_WBR, 0);
    // LDUR, 2 fetch waits + 3 mem waits
    add(J, 0, 0, C_FW, 1); add(J, 0, 0, C_FW, 1); add(O_LDUR, 1, 0, C_FD, 1);
    add(J, 0, 0, C_DEC0, 1); add(J, 0, 0, C_EXM, 1);
    add(J, 0, 0, C_MEMLD, 1); add(J, 0, 0, C_MEMLD, 1); add(J, 0, 0, C_MEMLD, 1);
    add(J, 1, 0, C_MEMLD, 1); add(J, 0, 0, C_WBLD, 1);
    // STUR
    add(O_STUR, 1, 0, C_FD, 2); add(J, 1, 0, C_DEC1, 2); add(J, 1, 0, C_EXM, 2); add(J, 1, 0, C_MEMST, 2);
    // CBZ taken / not taken
    add(O_CBZ0, 1, 0, C_FD, 3); add(J, 1, 0, C_DEC1, 3); add(J, 1, 1, C_BRZ1, 3);
    add(O_CBZ7, 1, 1, C_FD, 4); add(J, 1, 1, C_DEC1, 4); add(J, 1, 0, C_BRZ0, 4);
    // B
    add(O_B, 1, 0, C_FD, 5); add(J, 1, 0, C_DEC0, 5); add(J, 1, 0, C_BRB, 5);
    // SUB, AND (one fetch wait), ORR
    add(O_SUB, 1, 0, C_FD, 6); add(J, 1, 0, C_DEC0, 6); add(J, 1, 0, C_EXR, 6); add(J, 1, 0, C_WBR, 6);
    add(J, 0, 0, C_FW, 7); add(O_AND, 1, 0, C_FD, 7); add(J, 0, 0, C_DEC0, 7); add(J, 1, 0, C_EXR, 7); add(J, 1, 0, C_WBR, 7);
    add(O_ORR, 1, 0, C_FD, 8); add(J, 1, 0, C_DEC0, 8); add(J, 1, 0, C_EXR, 8); add(J, 1, 0, C_WBR, 8);
    // illegal -> HALT, sticky, count frozen
    add(11'h7FF, 1, 0, C_FD, 9); add(O_ADD, 1, 0, C_HALT, 9); add(O_ADD, 0, 0, C_HALT, 9); add(J, 1, 1, C_HALT, 9);

    for (int i = 0; i < vt.size(); i++) run_row(vt[i]);

    // reset releases HALT
    do_reset();

    // near-miss LDUR opcode is illegal
    step(J, 1, 0, C_IDLE, 0);
    step(11'h7C3, 1, 0, C_FD, 0);
    step(O_LDUR, 1, 0, C_HALT, 0);
    do_reset();

    // counter wrap: preload 0xFFFF_FFFF while in FETCH (non-retiring cycle)
    step(J, 1, 0, C_IDLE, 0);
    mif.opcode = O_ADD; mif.mem_ready = 1'b0;
    #2;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    step(J, 0, 0, C_FW, 32'hFFFF_FFFF);
    step(O_ADD, 1, 0, C_FD, 32'hFFFF_FFFF);
    step(J, 1, 0, C_DEC0, 32'hFFFF_FFFF);
    step(J, 1, 0, C_EXR, 32'hFFFF_FFFF);
    step(J, 1, 0, C_WBR, 32'hFFFF_FFFF);
    step(O_B, 1, 0, C_FD, 0);
    step(J, 1, 0, C_DEC0, 0);
    step(J, 1, 0, C_BRB, 0);

    // reset asserted mid-MEM of a store
    step(O_STUR, 1, 0, C_FD, 1);
    step(J, 1, 0, C_DEC1, 1);
    step(J, 1, 0, C_EXM, 1);
    step(J, 0, 0, C_MEMST, 1);
    chk("mid-mem req before reset", {31'd0, mif.mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-mem req after reset", {31'd0, mif.mem_req}, 32'd0);
    chk("mid-mem write after reset", {31'd0, mif.mem_write}, 32'd0);
    chk("mid-mem ctrl after reset", {17'd0, act_ctrl()}, 32'd0);
    chk("mid-mem count after reset", instr_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(J, 1, 0, C_IDLE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the LEGv8 datapath as a multi-cycle machine: one shared memory port for instructions and data, one ALU reused for PC increment, address generation and compare. It latches the opcode class at fetch, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every datapath enable and mux select. A ready handshake on the memory port lets memory insert wait states; an illegal opcode halts the machine until reset.

## Interface
- No parameters; widths fixed (opcode 11 bits, counter 32 bits).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  11  instruction[31:21] from the memory read-data bus, sampled only in FETCH when mem_ready=1
- alu_zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request (FETCH, MEM)
- mem_write  out  1  access is a store (valid with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result (PC+4), 1 = branch target
- reg_write  out  1  register-bank write enable
- reg2loc  out  1  read port 2 select: 0 = Rm, 1 = Rt
- mem_to_reg  out  1  write-back select: 0 = ALU result register, 1 = memory data register
- alu_src_a  out  1  0 = PC, 1 = read_data_1
- alu_src_b  out  2  00 = read_data_2, 01 = constant 4, 10 = sign-extended immediate
- alu_op  out  2  00 = add, 01 = pass B (zero test), 10 = function from opcode
- halted  out  1  illegal opcode seen; sticky until reset
- instr_count  out  32  retired instructions, wraps 0xFFFF_FFFF -> 0

## Operation
- Classes (decoded at fetch): R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx; anything else ILLEGAL.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT.
- IDLE: all outputs 0; -> FETCH next cycle.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. Hold while mem_ready=0. On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, latch class; -> DECODE (ILLEGAL -> HALT).
- DECODE: reg2loc=1 for STUR/CBZ else 0; -> EXEC for R/LDUR/STUR, -> BRANCH for CBZ/B.
- EXEC: alu_src_a=1; R: alu_src_b=00, alu_op=10 -> WB; LDUR/STUR: alu_src_b=10, alu_op=00 -> MEM.
- MEM: mem_req=1, iord=1, mem_write=1 for STUR. Hold while mem_ready=0. On ready: LDUR -> WB; STUR retires -> FETCH.
- WB: reg_write=1, mem_to_reg=1 for LDUR else 0; retires -> FETCH.
- BRANCH: CBZ: alu_src_a=1, reg2loc=1, alu_src_b=00, alu_op=01, pc_write=alu_zero, pc_src=1. B: pc_write=1, pc_src=1. Retires -> FETCH.
- HALT: all outputs 0 except halted=1; terminal.
- instr_count increments on the retiring cycle of every legal instruction (not on ILLEGAL).

## Timing
- Reset (async assert): state=IDLE, halted=0, instr_count=0, latched class cleared; all outputs 0 immediately.
- Reset mid-access: mem_req drops in the same cycle; no partial write-enable pulse survives.
- Zero-wait cycle counts: R 4, LDUR 5, STUR 4, CBZ/B 3. Each mem_ready=0 cycle adds one.
- Outputs are combinational from state, latched class, mem_ready and alu_zero; pc_write/ir_write in FETCH and reg_write are single-cycle pulses.
- mem_ready outside FETCH/MEM is ignored; mem_req never drops before mem_ready.
- opcode is ignored outside the FETCH completion cycle.

## Structure
- Shared package: state enum, class enum, opcode constants/masks, alu_op and alu_src_b encodings (shared with the ALU control and datapath muxes).
- Sub-module opcode_classifier: combinational 11-bit opcode -> class, unit-tested on its own.

## Test plan
- Reset then ADD with mem_ready tied 1 -> FETCH, DECODE, EXEC(alu_op=10), WB(reg_write=1); instr_count=1 after 4 cycles.
- LDUR with 2 wait cycles in FETCH and 3 in MEM -> mem_req held throughout, 10 cycles total, mem_to_reg=1 in WB.
- STUR -> MEM has mem_write=1, reg2loc=1 in DECODE, no reg_write; 4 cycles.
- CBZ alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH; alu_zero=0 -> pc_write=0; both retire in 3 cycles.
- Opcode 0x7FF -> HALT, halted=1, mem_req=0 forever, instr_count unchanged; reset_n low clears.
- Preload instr_count near 0xFFFF_FFFF via 2^32 retires (or force) -> next retire wraps to 0; reset_n asserted during MEM -> mem_req=0 same cycle.
